// File: rtl/scale_cache_writer_pkg.sv
// Shared sizes and types for the scale image cache and the downscaler that fills it.
// The writer and its per-axis selector import this package.
package pkg_scaleCache;

   localparam int scaleRowSize = 64;
   localparam int scaleColSize = 48;
   localparam int WORD_SIZE    = 8;
   localparam int ROW_WIDTH    = $clog2(scaleRowSize);
   localparam int COL_WIDTH    = $clog2(scaleColSize);
   localparam int ADDR_WIDTH   = $clog2(scaleRowSize * scaleColSize);

   localparam int          SCALE_FRAC_BITS = 8;
   localparam logic [15:0] SCALE_STEP_ONE  = 16'h0100;

   typedef logic [15:0] scale_step_t;
   typedef logic [23:0] scale_acc_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} scale_wr_state_t;

   // Steps below 1.0 would upscale; the cache only ever holds a shrunk copy.
   function automatic scale_step_t clamp_step(input scale_step_t step);
      return (step < SCALE_STEP_ONE) ? SCALE_STEP_ONE : step;
   endfunction

endpackage

// File: rtl/scale_axis_selector.sv
// One axis of the nearest-neighbour selector: a source counter plus a Q16.8
// position accumulator. A sample on this axis is kept when the two agree.
module scale_axis_selector
   import pkg_scaleCache::*;
#(
   parameter int CW        = 6,
   parameter int FRAC_BITS = SCALE_FRAC_BITS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        advance,
   input  logic        wrap,
   input  scale_step_t step,
   input  logic [CW:0] limit,
   output logic        keep,
   output logic        last
);

   logic [CW-1:0] count_reg;
   scale_acc_t    acc_reg;
   scale_acc_t    acc_int;

   assign acc_int = acc_reg >> FRAC_BITS;
   assign keep    = (scale_acc_t'(count_reg) == acc_int);
   assign last    = ({1'b0, count_reg} == (limit - (CW+1)'(1)));

   // The accumulator only moves past a kept sample, so it always points at
   // the next source index to keep.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= '0;
         acc_reg   <= '0;
      end else if (advance) begin
         if (wrap) begin
            count_reg <= '0;
            acc_reg   <= '0;
         end else begin
            count_reg <= count_reg + CW'(1);
            if (keep) begin
               acc_reg <= acc_reg + scale_acc_t'(step);
            end
         end
      end
   end

endmodule

// File: rtl/scale_cache_writer.sv
// Nearest-neighbour downscaler: keeps the raster pixels picked by a Q8.8
// inverse-scale step and writes them into the scale cache at a fixed row stride.
module scale_cache_writer
   import pkg_scaleCache::*;
#(
   parameter int ROW_SIZE   = pkg_scaleCache::scaleRowSize,
   parameter int COL_SIZE   = pkg_scaleCache::scaleColSize,
   parameter int WORD_SIZE  = pkg_scaleCache::WORD_SIZE,
   parameter int ADDR_WIDTH = pkg_scaleCache::ADDR_WIDTH,
   parameter int FRAC_BITS  = 8,
   parameter int ROW_WIDTH  = $clog2(ROW_SIZE),
   parameter int COL_WIDTH  = $clog2(COL_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ROW_WIDTH:0]    src_width,
   input  logic [COL_WIDTH:0]    src_height,
   input  logic [15:0]           scale_step,
   input  logic                  in_valid,
   input  logic [WORD_SIZE-1:0]  in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [WORD_SIZE-1:0]  wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [ROW_WIDTH:0]    dst_width,
   output logic [COL_WIDTH:0]    dst_height
);

   scale_wr_state_t       state_reg, state_next;
   scale_step_t           step_reg;
   logic [ROW_WIDTH:0]    width_reg;
   logic [COL_WIDTH:0]    height_reg;
   logic [ROW_WIDTH:0]    dst_col_reg;
   logic [ROW_WIDTH:0]    row0_cols_reg;
   logic [COL_WIDTH:0]    dst_row_reg;
   logic [ADDR_WIDTH-1:0] row_base_reg;

   logic                  launch;
   logic                  accept;
   logic                  write;
   logic                  row_end;
   logic                  x_keep, x_last;
   logic                  y_keep, y_last;
   logic [ROW_WIDTH:0]    cols_this_row;

   assign launch        = (state_reg == IDLE) && start;
   assign accept        = (state_reg == RUN) && in_valid;
   assign write         = accept && x_keep && y_keep;
   assign row_end       = accept && x_last;
   assign cols_this_row = dst_col_reg + {{ROW_WIDTH{1'b0}}, write};

   assign in_ready = (state_reg == RUN);
   assign busy     = (state_reg == RUN);
   assign done     = (state_reg == DONE);

   scale_axis_selector #(
      .CW        (ROW_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_x_sel (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch),
      .advance (accept),
      .wrap    (x_last),
      .step    (step_reg),
      .limit   (width_reg),
      .keep    (x_keep),
      .last    (x_last)
   );

   // Rows never wrap inside a frame; the frame ends on the last row instead.
   scale_axis_selector #(
      .CW        (COL_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_y_sel (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch),
      .advance (row_end),
      .wrap    (1'b0),
      .step    (step_reg),
      .limit   (height_reg),
      .keep    (y_keep),
      .last    (y_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (row_end && y_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_reg      <= '0;
         width_reg     <= '0;
         height_reg    <= '0;
         dst_col_reg   <= '0;
         row0_cols_reg <= '0;
         dst_row_reg   <= '0;
         row_base_reg  <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         dst_width     <= '0;
         dst_height    <= '0;
      end else begin
         wr_en <= write;
         if (write) begin
            wr_addr <= row_base_reg + ADDR_WIDTH'(dst_col_reg);
            wr_data <= in_data;
         end

         if (launch) begin
            step_reg      <= clamp_step(scale_step);
            width_reg     <= src_width;
            height_reg    <= src_height;
            dst_col_reg   <= '0;
            row0_cols_reg <= '0;
            dst_row_reg   <= '0;
            row_base_reg  <= '0;
            dst_width     <= '0;
            dst_height    <= '0;
         end else if (accept) begin
            if (x_last) begin
               dst_col_reg <= '0;
               // Row 0 is always kept, so dst_row_reg is zero only while in it.
               if (dst_row_reg == '0) begin
                  row0_cols_reg <= cols_this_row;
               end
               if (y_keep) begin
                  dst_row_reg  <= dst_row_reg + (COL_WIDTH+1)'(1);
                  row_base_reg <= row_base_reg + ADDR_WIDTH'(ROW_SIZE);
               end
               if (y_last) begin
                  dst_width  <= (dst_row_reg == '0) ? cols_this_row : row0_cols_reg;
                  dst_height <= dst_row_reg + {{COL_WIDTH{1'b0}}, y_keep};
               end
            end else if (write) begin
               dst_col_reg <= cols_this_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_scale_cache_writer.sv
// Self-checking bench for scale_cache_writer: table-driven frames, hand-written
// corner sequences and random frames, all checked against a keep-list model.
module tb_scale_cache_writer;

   localparam int R  = pkg_scaleCache::scaleRowSize;
   localparam int RW = pkg_scaleCache::ROW_WIDTH;
   localparam int CW = pkg_scaleCache::COL_WIDTH;
   localparam int AW = pkg_scaleCache::ADDR_WIDTH;
   localparam int DW = pkg_scaleCache::WORD_SIZE;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [RW:0]   src_width = '0;
   logic [CW:0]   src_height = '0;
   logic [15:0]   scale_step = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, wr_en, busy, done;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [RW:0]   dst_width;
   logic [CW:0]   dst_height;

   always #5 clk = ~clk;

   scale_cache_writer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_width  (src_width),
      .src_height (src_height),
      .scale_step (scale_step),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .dst_width  (dst_width),
      .dst_height (dst_height)
   );

   typedef struct { int addr; int data; } wr_t;
   typedef struct { int w; int h; int st; int gap; int ew; int eh; int en; } vec_t;

   wr_t  got_q[$];
   wr_t  exp_q[$];
   wr_t  ref_q[$];
   logic [DW-1:0] pix [0:47][0:63];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int acc_cyc  = 0;
   int got_dw   = 0;
   int got_dh   = 0;
   int exp_w    = 0;
   int exp_h    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) got_q.push_back('{addr: int'(wr_addr), data: int'(wr_data)});
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         got_dw   = int'(dst_width);
         got_dh   = int'(dst_height);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_frame(input int mode);
      for (int y = 0; y < 48; y++)
         for (int x = 0; x < 64; x++)
            pix[y][x] = (mode == 0) ? DW'(16 * y + x) : DW'($urandom);
   endtask

   // Kept indices are floor(k*step) below the limit; writes go out row by row.
   task automatic build_model(input int w, input int h, input int st);
      int s;
      int kc[$];
      int kr[$];
      s = (st < 256) ? 256 : st;
      for (int k = 0; (k * s) / 256 < w; k++) kc.push_back((k * s) / 256);
      for (int k = 0; (k * s) / 256 < h; k++) kr.push_back((k * s) / 256);
      exp_q.delete();
      foreach (kr[j])
         foreach (kc[i])
            exp_q.push_back('{addr: j * R + i, data: int'(pix[kr[j]][kc[i]])});
      exp_w = kc.size();
      exp_h = kr.size();
   endtask

   task automatic check_outputs_zero();
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_dst_width", dst_width, 0);
      check("rst_dst_height", dst_height, 0);
   endtask

   task automatic run_frame(input int w, input int h, input int st, input int gap,
                            input bit poke, input int abort_at);
      int  idx;
      int  budget;
      int  d0;
      bit  acc;
      idx = 0;
      budget = 0;
      got_q.delete();
      build_model(w, h, st);
      d0 = done_cnt;
      @(posedge clk); #1;
      start      = 1'b1;
      src_width  = (RW+1)'(w);
      src_height = (CW+1)'(h);
      scale_step = 16'(st);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      while (idx < w * h && budget < 4000) begin
         if (abort_at >= 0 && idx == abort_at) break;
         in_valid = ($urandom_range(99) >= gap);
         in_data  = pix[idx / w][idx % w];
         if (poke && idx == 3) begin
            start = 1'b1; src_width = 1; src_height = 1; scale_step = 16'h0400;
         end else begin
            start = 1'b0;
         end
         acc = in_valid && in_ready;
         if (acc) acc_cyc = cyc;
         @(posedge clk); #1;
         if (acc) idx++;
         budget++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (abort_at >= 0) begin
         reset = 1'b1;
         @(posedge clk); #1;
         check_outputs_zero();
         reset = 1'b0;
         repeat (w * h + 5) @(posedge clk);
         #1;
         check("abort_no_done", done_cnt - d0, 0);
         $display("frame %0dx%0d step=%04h aborted after %0d accepts", w, h, st, idx);
         return;
      end
      check("frame_accepts", idx, w * h);
      budget = 0;
      while (done_cnt == d0 && budget < 10) begin
         @(posedge clk); #1;
         budget++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("done_pulses", done_cnt - d0, 1);
      check("done_latency", done_cyc, acc_cyc + 1);
      check("dst_width", got_dw, exp_w);
      check("dst_height", got_dh, exp_h);
      check("wr_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check("wr_addr", got_q[i].addr, exp_q[i].addr);
         check("wr_data", got_q[i].data, exp_q[i].data);
      end
      $display("frame %0dx%0d step=%04h gap=%0d writes=%0d dst=%0dx%0d",
               w, h, st, gap, got_q.size(), got_dw, got_dh);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[7];
      tbl[0] = '{w: 4,  h: 3, st: 'h100, gap: 0,  ew: 4,  eh: 3, en: 12};
      tbl[1] = '{w: 4,  h: 4, st: 'h200, gap: 0,  ew: 2,  eh: 2, en: 4};
      tbl[2] = '{w: 6,  h: 1, st: 'h180, gap: 0,  ew: 4,  eh: 1, en: 4};
      tbl[3] = '{w: 4,  h: 3, st: 'h080, gap: 0,  ew: 4,  eh: 3, en: 12};
      tbl[4] = '{w: 1,  h: 1, st: 'h300, gap: 0,  ew: 1,  eh: 1, en: 1};
      tbl[5] = '{w: 5,  h: 5, st: 'h400, gap: 25, ew: 2,  eh: 2, en: 4};
      tbl[6] = '{w: 64, h: 2, st: 'h100, gap: 20, ew: 64, eh: 2, en: 128};

      fill_frame(0);
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero();
      reset = 1'b0;

      foreach (tbl[t]) begin
         run_frame(tbl[t].w, tbl[t].h, tbl[t].st, tbl[t].gap, 1'b0, -1);
         check("tbl_dst_width", got_dw, tbl[t].ew);
         check("tbl_dst_height", got_dh, tbl[t].eh);
         check("tbl_wr_count", got_q.size(), tbl[t].en);
      end

      // Step 2.0 over data 16*y+x: explicit addresses and values.
      run_frame(4, 4, 'h200, 0, 1'b0, -1);
      if (got_q.size() == 4) begin
         check("s2_addr0", got_q[0].addr, 0);     check("s2_data0", got_q[0].data, 'h00);
         check("s2_addr1", got_q[1].addr, 1);     check("s2_data1", got_q[1].data, 'h02);
         check("s2_addr2", got_q[2].addr, R);     check("s2_data2", got_q[2].data, 'h20);
         check("s2_addr3", got_q[3].addr, R + 1); check("s2_data3", got_q[3].data, 'h22);
      end

      // Identity: row 1 starts at the row stride.
      run_frame(4, 3, 'h100, 0, 1'b0, -1);
      if (got_q.size() == 12) begin
         check("id_addr4", got_q[4].addr, R);
         check("id_addr11", got_q[11].addr, 2 * R + 3);
      end

      // Gap-free reference, then gapped run with start poked during RUN.
      fill_frame(1);
      run_frame(7, 5, 'h150, 0, 1'b0, -1);
      ref_q = got_q;
      run_frame(7, 5, 'h150, 50, 1'b1, -1);
      check("bp_count", got_q.size(), ref_q.size());
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
         check("bp_addr", got_q[i].addr, ref_q[i].addr);
         check("bp_data", got_q[i].data, ref_q[i].data);
      end

      // Reset after five accepts, then a clean frame.
      run_frame(4, 3, 'h100, 0, 1'b0, 5);
      run_frame(4, 3, 'h100, 10, 1'b0, -1);

      for (int n = 0; n < 6; n++) begin
         fill_frame(1);
         run_frame($urandom_range(1, 12), $urandom_range(1, 6),
                   $urandom_range('h40, 'h380), 30, 1'b1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
